// File: rtl/alpide_ldo_pkg.sv
// Shared definitions for the ALPIDE LDO power controller: state and fault
// cause encodings, register map, CMD bit positions and reset values.
package alpide_ldo_pkg;

   typedef enum logic [2:0] {
      ST_OFF   = 3'd0,
      ST_RAMP  = 3'd1,
      ST_ON    = 3'd2,
      ST_FAULT = 3'd3,
      ST_COOL  = 3'd4
   } state_e;

   typedef enum logic [1:0] {
      CAUSE_NONE   = 2'd0,
      CAUSE_OCP    = 2'd1,
      CAUSE_PGTMO  = 2'd2,
      CAUSE_PGLOSS = 2'd3
   } cause_e;

   localparam logic [7:0] ADDR_STATUS  = 8'h00;
   localparam logic [7:0] ADDR_CMD     = 8'h01;
   localparam logic [7:0] ADDR_TPGOOD  = 8'h02;
   localparam logic [7:0] ADDR_TBLANK  = 8'h03;
   localparam logic [7:0] ADDR_TOFF    = 8'h04;
   localparam logic [7:0] ADDR_TRIPCNT = 8'h05;

   localparam int CMD_ON       = 0;
   localparam int CMD_OFF      = 1;
   localparam int CMD_CLRFAULT = 2;
   localparam int CMD_CLRCNT   = 3;

   localparam logic [15:0] READ_UNMAPPED = 16'hF001;
   localparam logic [15:0] TIMER_RESET   = 16'hFFFF;

   // Trip counter increment that sticks at 255.
   function automatic logic [7:0] sat_inc8(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

endpackage

// File: rtl/alpide_ldo_ctrl_if.sv
// Register port of the LDO controller: 8-bit address, 16-bit write data,
// single-cycle write strobe, combinational read data.
//   master: drives reg_we_i / reg_addr_i / reg_data_i, samples reg_data_o
//   slave : the controller
interface alpide_ldo_ctrl_if;
   logic        reg_we_i;
   logic [7:0]  reg_addr_i;
   logic [15:0] reg_data_i;
   logic [15:0] reg_data_o;

   modport master (output reg_we_i, reg_addr_i, reg_data_i, input reg_data_o);
   modport slave  (input reg_we_i, reg_addr_i, reg_data_i, output reg_data_o);
endinterface

// File: rtl/alpide_sync2.sv
// Two-flop synchroniser for a single asynchronous level.
//   clk_i   : destination clock
//   rst_n_i : asynchronous active-low reset, clears both flops
//   d_i     : asynchronous input
//   q_o     : synchronised output, two cycles of latency
module alpide_sync2 (
   input  logic clk_i,
   input  logic rst_n_i,
   input  logic d_i,
   output logic q_o
);
   logic meta_q;

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         meta_q <= 1'b0;
         q_o    <= 1'b0;
      end else begin
         meta_q <= d_i;
         q_o    <= meta_q;
      end
   end
endmodule

// File: rtl/alpide_ldo_ctrl.sv
// Power controller for one ALPIDE sensor LDO. Enables the LDO on command,
// checks power-good within a timeout, trips on overcurrent (after an inrush
// blanking window) or power-good loss, and holds the LDO off for a minimum
// cool-down time before it may be re-enabled.
//   clk_i    : system clock
//   rst_n_i  : asynchronous active-low reset
//   bus      : register port (slave side)
//   pgood_i  : LDO power-good, asynchronous
//   ocp_i    : LDO overcurrent flag, asynchronous
//   ldo_en_o : LDO enable, registered
//   fault_o  : high while in FAULT, registered
module alpide_ldo_ctrl
   import alpide_ldo_pkg::*;
#(
   parameter int unsigned PRESCALE = 1000
) (
   input  logic              clk_i,
   input  logic              rst_n_i,
   alpide_ldo_ctrl_if.slave  bus,
   input  logic              pgood_i,
   input  logic              ocp_i,
   output logic              ldo_en_o,
   output logic              fault_o
);
   localparam int unsigned PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [PS_W-1:0] PS_MAX = PS_W'(PRESCALE - 1);

   logic            pg_s, oc_s;
   logic [PS_W-1:0] ps_q;
   logic            tick;
   logic [15:0]     tpgood_q, tblank_q, toff_cfg_q;
   logic [15:0]     tpg_q, tbl_q, toff_q;
   state_e          state_q;
   cause_e          cause_q;
   logic [7:0]      trip_cnt_q;
   logic            wr_cmd, cmd_on, cmd_off, cmd_clrfault, cmd_clrcnt;
   logic            trip;

   alpide_sync2 u_sync_pg (.clk_i(clk_i), .rst_n_i(rst_n_i), .d_i(pgood_i), .q_o(pg_s));
   alpide_sync2 u_sync_oc (.clk_i(clk_i), .rst_n_i(rst_n_i), .d_i(ocp_i),   .q_o(oc_s));

   // Free-running prescaler; tick marks the last cycle of each period.
   assign tick = (ps_q == PS_MAX);

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) ps_q <= '0;
      else          ps_q <= tick ? '0 : ps_q + 1'b1;
   end

   assign wr_cmd       = bus.reg_we_i && (bus.reg_addr_i == ADDR_CMD);
   assign cmd_on       = wr_cmd && bus.reg_data_i[CMD_ON];
   assign cmd_off      = wr_cmd && bus.reg_data_i[CMD_OFF];
   assign cmd_clrfault = wr_cmd && bus.reg_data_i[CMD_CLRFAULT];
   assign cmd_clrcnt   = wr_cmd && bus.reg_data_i[CMD_CLRCNT];

   // Timer configuration registers.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         tpgood_q   <= TIMER_RESET;
         tblank_q   <= TIMER_RESET;
         toff_cfg_q <= TIMER_RESET;
      end else if (bus.reg_we_i) begin
         case (bus.reg_addr_i)
            ADDR_TPGOOD: tpgood_q   <= bus.reg_data_i;
            ADDR_TBLANK: tblank_q   <= bus.reg_data_i;
            ADDR_TOFF:   toff_cfg_q <= bus.reg_data_i;
            default: ;
         endcase
      end
   end

   // Fault entry this cycle; shared by the FSM and the trip counter.
   always_comb begin
      trip = 1'b0;
      case (state_q)
         ST_RAMP: trip = (oc_s && tbl_q == 16'd0) || (tpg_q == 16'd0 && !pg_s);
         ST_ON:   trip = oc_s || !pg_s;
         default: trip = 1'b0;
      endcase
   end

   // The increment takes precedence over a simultaneous clear.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i)        trip_cnt_q <= 8'd0;
      else if (trip)       trip_cnt_q <= sat_inc8(trip_cnt_q);
      else if (cmd_clrcnt) trip_cnt_q <= 8'd0;
   end

   // Control FSM. Timers count down on tick and rest at zero; a state entry
   // reloads the relevant timer, overriding the countdown on that edge.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q  <= ST_OFF;
         cause_q  <= CAUSE_NONE;
         ldo_en_o <= 1'b0;
         fault_o  <= 1'b0;
         tpg_q    <= TIMER_RESET;
         tbl_q    <= TIMER_RESET;
         toff_q   <= TIMER_RESET;
      end else begin
         if (tick && tpg_q  != 16'd0) tpg_q  <= tpg_q  - 16'd1;
         if (tick && tbl_q  != 16'd0) tbl_q  <= tbl_q  - 16'd1;
         if (tick && toff_q != 16'd0) toff_q <= toff_q - 16'd1;

         case (state_q)
            ST_OFF: begin
               // ON together with OFF is a no-op.
               if (cmd_on && !cmd_off) begin
                  state_q  <= ST_RAMP;
                  ldo_en_o <= 1'b1;
                  tpg_q    <= tpgood_q;
                  tbl_q    <= tblank_q;
               end
            end
            ST_RAMP: begin
               if (oc_s && tbl_q == 16'd0) begin
                  state_q  <= ST_FAULT;
                  cause_q  <= CAUSE_OCP;
                  ldo_en_o <= 1'b0;
                  fault_o  <= 1'b1;
               end else if (tpg_q == 16'd0 && !pg_s) begin
                  state_q  <= ST_FAULT;
                  cause_q  <= CAUSE_PGTMO;
                  ldo_en_o <= 1'b0;
                  fault_o  <= 1'b1;
               end else if (cmd_off) begin
                  state_q  <= ST_COOL;
                  ldo_en_o <= 1'b0;
                  toff_q   <= toff_cfg_q;
               end else if (pg_s && tbl_q == 16'd0) begin
                  state_q  <= ST_ON;
               end
            end
            ST_ON: begin
               if (oc_s) begin
                  state_q  <= ST_FAULT;
                  cause_q  <= CAUSE_OCP;
                  ldo_en_o <= 1'b0;
                  fault_o  <= 1'b1;
               end else if (!pg_s) begin
                  state_q  <= ST_FAULT;
                  cause_q  <= CAUSE_PGLOSS;
                  ldo_en_o <= 1'b0;
                  fault_o  <= 1'b1;
               end else if (cmd_off) begin
                  state_q  <= ST_COOL;
                  ldo_en_o <= 1'b0;
                  toff_q   <= toff_cfg_q;
               end
            end
            ST_FAULT: begin
               if (cmd_clrfault) begin
                  state_q <= ST_COOL;
                  cause_q <= CAUSE_NONE;
                  fault_o <= 1'b0;
                  toff_q  <= toff_cfg_q;
               end
            end
            ST_COOL: begin
               // ON commands are dropped here, not remembered.
               if (toff_q == 16'd0) state_q <= ST_OFF;
            end
            default: begin
               state_q  <= ST_OFF;
               ldo_en_o <= 1'b0;
               fault_o  <= 1'b0;
            end
         endcase
      end
   end

   // Read decode.
   always_comb begin
      bus.reg_data_o = READ_UNMAPPED;
      case (bus.reg_addr_i)
         ADDR_STATUS:  bus.reg_data_o = {9'b0, state_q, cause_q, pg_s, ldo_en_o};
         ADDR_CMD:     bus.reg_data_o = 16'h0000;
         ADDR_TPGOOD:  bus.reg_data_o = tpgood_q;
         ADDR_TBLANK:  bus.reg_data_o = tblank_q;
         ADDR_TOFF:    bus.reg_data_o = toff_cfg_q;
         ADDR_TRIPCNT: bus.reg_data_o = {8'b0, trip_cnt_q};
         default:      bus.reg_data_o = READ_UNMAPPED;
      endcase
   end

endmodule

// File: tb/tb_alpide_ldo_ctrl.sv
// Directed bench for alpide_ldo_ctrl with PRESCALE=4, TPGOOD=10, TBLANK=2, TOFF=5.
module tb_alpide_ldo_ctrl;

   logic clk_i = 1'b0;
   logic rst_n_i;
   logic pgood_i, ocp_i;
   logic ldo_en_o, fault_o;
   int   checks = 0;
   int   errors = 0;

   alpide_ldo_ctrl_if bus ();

   alpide_ldo_ctrl #(.PRESCALE(4)) dut (
      .clk_i    (clk_i),
      .rst_n_i  (rst_n_i),
      .bus      (bus),
      .pgood_i  (pgood_i),
      .ocp_i    (ocp_i),
      .ldo_en_o (ldo_en_o),
      .fault_o  (fault_o)
   );

   always #5 clk_i = ~clk_i;

   // Write lands on the next rising edge; returns 1ns after that edge.
   task automatic wr(input logic [7:0] a, input logic [15:0] d);
      @(negedge clk_i);
      bus.reg_we_i   = 1'b1;
      bus.reg_addr_i = a;
      bus.reg_data_i = d;
      @(posedge clk_i);
      #1;
      bus.reg_we_i   = 1'b0;
      bus.reg_data_i = 16'h0000;
   endtask

   task automatic rd(input logic [7:0] a, output logic [15:0] d);
      bus.reg_addr_i = a;
      #1;
      d = bus.reg_data_o;
   endtask

   task automatic wait_state(input logic [2:0] st, input int maxc, output int n, output bit ok);
      logic [15:0] s;
      ok = 1'b0;
      n  = 0;
      for (int i = 0; i < maxc; i++) begin
         @(posedge clk_i);
         #1;
         n++;
         rd(8'h00, s);
         if (s[6:4] == st) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic test_reset();
      logic [15:0] d;
      #12;
      checks++; if (ldo_en_o !== 1'b0) begin errors++; $display("FAIL reset_ldo_en got %b want 0", ldo_en_o); end
      checks++; if (fault_o !== 1'b0) begin errors++; $display("FAIL reset_fault got %b want 0", fault_o); end
      rd(8'h00, d);
      checks++; if (d !== 16'h0000) begin errors++; $display("FAIL reset_status got %h want 0000", d); end
      rd(8'h02, d);
      checks++; if (d !== 16'hFFFF) begin errors++; $display("FAIL reset_tpgood got %h want ffff", d); end
      rd(8'h03, d);
      checks++; if (d !== 16'hFFFF) begin errors++; $display("FAIL reset_tblank got %h want ffff", d); end
      rd(8'h04, d);
      checks++; if (d !== 16'hFFFF) begin errors++; $display("FAIL reset_toff got %h want ffff", d); end
      rd(8'h7F, d);
      checks++; if (d !== 16'hF001) begin errors++; $display("FAIL reset_unmapped got %h want f001", d); end
      rd(8'h05, d);
      checks++; if (d !== 16'h0000) begin errors++; $display("FAIL reset_tripcnt got %h want 0000", d); end
      @(negedge clk_i);
      rst_n_i = 1'b1;
      wr(8'h02, 16'd10);
      wr(8'h03, 16'd2);
      wr(8'h04, 16'd5);
      wr(8'h00, 16'h1234);
      rd(8'h02, d);
      checks++; if (d !== 16'd10) begin errors++; $display("FAIL cfg_tpgood got %h want 000a", d); end
      rd(8'h00, d);
      checks++; if (d !== 16'h0000) begin errors++; $display("FAIL ro_status_write got %h want 0000", d); end
   endtask

   task automatic test_power_up();
      logic [15:0] s;
      wr(8'h01, 16'h0001);
      rd(8'h00, s);
      checks++; if (ldo_en_o !== 1'b1) begin errors++; $display("FAIL pu_en_on_write got %b want 1", ldo_en_o); end
      checks++; if (s[6:4] !== 3'd1) begin errors++; $display("FAIL pu_ramp got %0d want 1", s[6:4]); end
      repeat (12) @(posedge clk_i);
      @(negedge clk_i);
      pgood_i = 1'b1;
      repeat (2) @(posedge clk_i);
      #1;
      rd(8'h00, s);
      checks++; if (s[1] !== 1'b1 || s[6:4] !== 3'd1) begin errors++; $display("FAIL pu_sync got pg=%b st=%0d want pg=1 st=1", s[1], s[6:4]); end
      @(posedge clk_i);
      #1;
      rd(8'h00, s);
      checks++; if (s !== 16'h0023) begin errors++; $display("FAIL pu_on got %h want 0023", s); end
   endtask

   task automatic test_off_cooldown();
      logic [15:0] s;
      int n;
      bit ok;
      wr(8'h01, 16'h0002);
      rd(8'h00, s);
      checks++; if (ldo_en_o !== 1'b0 || s[6:4] !== 3'd4) begin errors++; $display("FAIL off_cool got en=%b st=%0d want en=0 st=4", ldo_en_o, s[6:4]); end
      wr(8'h01, 16'h0001);
      rd(8'h00, s);
      checks++; if (ldo_en_o !== 1'b0 || s[6:4] !== 3'd4) begin errors++; $display("FAIL cool_on_ignored got en=%b st=%0d want en=0 st=4", ldo_en_o, s[6:4]); end
      wait_state(3'd0, 40, n, ok);
      checks++; if (!ok) begin errors++; $display("FAIL cool_to_off got timeout want state 0"); end
      repeat (3) @(posedge clk_i);
      #1;
      rd(8'h00, s);
      checks++; if (s[6:4] !== 3'd0 || ldo_en_o !== 1'b0) begin errors++; $display("FAIL on_not_queued got st=%0d en=%b want st=0 en=0", s[6:4], ldo_en_o); end
      wr(8'h01, 16'h0001);
      rd(8'h00, s);
      checks++; if (s[6:4] !== 3'd1 || ldo_en_o !== 1'b1) begin errors++; $display("FAIL reenable got st=%0d en=%b want st=1 en=1", s[6:4], ldo_en_o); end
      wr(8'h01, 16'h0002);
      rd(8'h00, s);
      checks++; if (s[6:4] !== 3'd4 || ldo_en_o !== 1'b0) begin errors++; $display("FAIL ramp_off got st=%0d en=%b want st=4 en=0", s[6:4], ldo_en_o); end
      wait_state(3'd0, 40, n, ok);
      checks++; if (!ok) begin errors++; $display("FAIL cool_to_off2 got timeout want state 0"); end
      wr(8'h01, 16'h0003);
      rd(8'h00, s);
      checks++; if (s[6:4] !== 3'd0 || ldo_en_o !== 1'b0) begin errors++; $display("FAIL on_off_together got st=%0d en=%b want st=0 en=0", s[6:4], ldo_en_o); end
   endtask

   task automatic test_timeout();
      logic [15:0] s;
      int n;
      bit ok;
      @(negedge clk_i);
      pgood_i = 1'b0;
      repeat (3) @(posedge clk_i);
      wr(8'h01, 16'h0001);
      n = 0;
      for (int i = 0; i < 60; i++) begin
         @(posedge clk_i);
         #1;
         n++;
         if (fault_o === 1'b1) break;
      end
      // 10 ticks of 4 cycles, minus up to one tick, plus the transition edge.
      checks++; if (n < 36 || n > 44) begin errors++; $display("FAIL tmo_latency got %0d cycles want 36..44", n); end
      rd(8'h00, s);
      checks++; if (s !== 16'h0038 || fault_o !== 1'b1 || ldo_en_o !== 1'b0) begin errors++; $display("FAIL tmo_status got %h f=%b en=%b want 0038 f=1 en=0", s, fault_o, ldo_en_o); end
      rd(8'h05, s);
      checks++; if (s !== 16'd1) begin errors++; $display("FAIL tmo_tripcnt got %0d want 1", s); end
      wr(8'h01, 16'h0004);
      rd(8'h00, s);
      checks++; if (s !== 16'h0040 || fault_o !== 1'b0) begin errors++; $display("FAIL tmo_clrfault got %h f=%b want 0040 f=0", s, fault_o); end
      wait_state(3'd0, 40, n, ok);
      checks++; if (!ok) begin errors++; $display("FAIL tmo_to_off got timeout want state 0"); end
   endtask

   task automatic test_ocp();
      logic [15:0] s;
      int n;
      bit ok;
      @(negedge clk_i);
      pgood_i = 1'b1;
      repeat (3) @(posedge clk_i);
      wr(8'h01, 16'h0001);
      @(negedge clk_i);
      ocp_i = 1'b1;
      @(negedge clk_i);
      @(negedge clk_i);
      ocp_i = 1'b0;
      wait_state(3'd2, 40, n, ok);
      checks++; if (!ok || fault_o !== 1'b0) begin errors++; $display("FAIL ocp_blank got ok=%b f=%b want ok=1 f=0", ok, fault_o); end
      @(negedge clk_i);
      ocp_i = 1'b1;
      wait_state(3'd3, 10, n, ok);
      rd(8'h00, s);
      checks++; if (!ok || s !== 16'h0036 || ldo_en_o !== 1'b0) begin errors++; $display("FAIL ocp_trip got %h en=%b want 0036 en=0", s, ldo_en_o); end
      rd(8'h05, s);
      checks++; if (s !== 16'd2) begin errors++; $display("FAIL ocp_tripcnt got %0d want 2", s); end
      @(negedge clk_i);
      ocp_i = 1'b0;
      wr(8'h01, 16'h0004);
      rd(8'h00, s);
      checks++; if (s[6:4] !== 3'd4 || s[3:2] !== 2'd0) begin errors++; $display("FAIL ocp_clr got st=%0d cause=%0d want st=4 cause=0", s[6:4], s[3:2]); end
      wait_state(3'd0, 40, n, ok);
      // 5 ticks minus up to one, plus the transition edge.
      checks++; if (!ok || n < 16 || n > 21) begin errors++; $display("FAIL ocp_cool_time got %0d cycles want 16..21", n); end
   endtask

   task automatic test_async_and_saturation();
      logic [15:0] s;
      @(negedge clk_i);
      pgood_i = 1'b0;
      repeat (3) @(posedge clk_i);
      wr(8'h01, 16'h0001);
      checks++; if (ldo_en_o !== 1'b1) begin errors++; $display("FAIL async_pre got %b want 1", ldo_en_o); end
      @(negedge clk_i);
      #2;
      rst_n_i = 1'b0;
      #1;
      checks++; if (ldo_en_o !== 1'b0 || fault_o !== 1'b0) begin errors++; $display("FAIL async_drop got en=%b f=%b want 0 0", ldo_en_o, fault_o); end
      rd(8'h00, s);
      checks++; if (s !== 16'h0000) begin errors++; $display("FAIL async_status got %h want 0000", s); end
      rd(8'h05, s);
      checks++; if (s !== 16'h0000) begin errors++; $display("FAIL async_tripcnt got %h want 0000", s); end
      @(negedge clk_i);
      rst_n_i = 1'b1;
      wr(8'h02, 16'd0);
      wr(8'h04, 16'd0);
      for (int i = 0; i < 255; i++) begin
         wr(8'h01, 16'h0001);
         @(posedge clk_i);
         wr(8'h01, 16'h0004);
         @(posedge clk_i);
      end
      rd(8'h05, s);
      checks++; if (s !== 16'd255) begin errors++; $display("FAIL trip_255 got %0d want 255", s); end
      wr(8'h01, 16'h0001);
      @(posedge clk_i);
      wr(8'h01, 16'h0004);
      @(posedge clk_i);
      rd(8'h05, s);
      checks++; if (s !== 16'd255) begin errors++; $display("FAIL trip_sat got %0d want 255", s); end
      wr(8'h01, 16'h0008);
      rd(8'h05, s);
      checks++; if (s !== 16'd0) begin errors++; $display("FAIL clrcnt got %0d want 0", s); end
      // CLRCNT+OFF on the trip edge: fault and increment both win.
      wr(8'h01, 16'h0001);
      wr(8'h01, 16'h000A);
      rd(8'h05, s);
      checks++; if (s !== 16'd1) begin errors++; $display("FAIL inc_beats_clr got %0d want 1", s); end
      rd(8'h00, s);
      checks++; if (s[6:4] !== 3'd3 || fault_o !== 1'b1) begin errors++; $display("FAIL fault_beats_off got st=%0d f=%b want st=3 f=1", s[6:4], fault_o); end
   endtask

   initial begin
      rst_n_i        = 1'b0;
      pgood_i        = 1'b0;
      ocp_i          = 1'b0;
      bus.reg_we_i   = 1'b0;
      bus.reg_addr_i = 8'h00;
      bus.reg_data_i = 16'h0000;
      test_reset();
      test_power_up();
      test_off_cooldown();
      test_timeout();
      test_ocp();
      test_async_and_saturation();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog got timeout want completion");
      $fatal(1, "watchdog");
   end

endmodule
